prim_sel_sequencer: RTL and testbench
=====================================

Name: prim_sel_sequencer

Overview:
Upstream command sequencer that drives the 19-bit one-hot sel_prim bus of the primitive-select decoder.
- Accepts primitive commands {id, len} over a valid/ready interface and buffers them in a small FIFO.
- Issues each command as a registered one-hot sel_prim held for len cycles.
- Inserts exactly one all-zero cycle between issues, so the decoder always sees its idle/default code between primitives.

Parameters:
NPRIM, 19, number of primitives; width of sel_prim.
ID_W, 5, width of cmd_id.
LEN_W, 4, width of cmd_len and of the hold counter.
DEPTH, 4, FIFO entries (power of 2).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept a command.
cmd_id  in  ID_W  primitive index, 0..NPRIM-1.
cmd_len  in  LEN_W  hold cycles; 0 is treated as 1.
abort  in  1  synchronous flush of the FIFO and of the current issue.
sel_prim  out  NPRIM  registered one-hot select; all-zero when idle.
busy  out  1  FIFO non-empty or state != IDLE.
done  out  1  one-cycle pulse when an issue completes normally.
err_id  out  1  one-cycle pulse for an accepted command with id >= NPRIM.

Behaviour:
- Reset: one clock is used; reset is synchronous and active-high. On the rst edge:
  - FIFO empty; state IDLE.
  - sel_prim=0, done=0, err_id=0, busy=0.
  - cmd_ready=1 in the first cycle after reset.
- Reset mid-issue: sel_prim is 0 after the rst edge, with no done pulse.
- Accept: push occurs on an edge where cmd_valid & cmd_ready.
  - cmd_ready = !full & !abort (combinational from the registered count).
  - Push is blocked when the FIFO is full, even if a pop happens in the same cycle.
- Invalid id: id >= NPRIM is accepted (it consumes the handshake) but is not written to the FIFO. err_id=1 for the cycle after the accept edge.
- Simultaneous push and pop on a non-full, non-empty FIFO is legal; count is unchanged.
- FSM states:
  - IDLE: sel_prim=0. If the FIFO is non-empty at an edge: pop; load cnt = max(len,1); sel_prim <= onehot(id); go to ISSUE.
  - ISSUE: sel_prim held. Each edge, cnt decrements. At the edge where cnt==1: sel_prim <= 0, done <= 1, go to GAP.
  - GAP: sel_prim=0, done=1 for this single cycle. At the next edge: if the FIFO is non-empty, pop and go straight to ISSUE (same actions as IDLE); otherwise go to IDLE.
- Latency:
  - Command accepted at edge k into an empty, IDLE block: sel_prim is valid after edge k+1.
  - sel_prim stays asserted for exactly max(len,1) cycles.
  - Back-to-back commands see exactly one zero cycle between them.
- Invariant: sel_prim is either 0 or exactly one-hot. It never holds multiple bits and never glitches through a combinational path.
- Abort, at the edge where it is sampled:
  - FIFO is emptied, state goes to IDLE, sel_prim=0.
  - No done pulse; any pending err_id is cleared.
  - A command presented in the same cycle is not accepted.
- rst has priority over abort; abort has priority over push and pop.
- done and err_id are registered single-cycle pulses and can assert in the same cycle.
- FIFO pointers wrap modulo DEPTH.
- The count is LEN_W-independent: log2(DEPTH)+1 bits, holding 0..DEPTH.

Test Plan:
- Basic issue: after reset, push id=5, len=3 at edge 2 -> sel_prim=0x00020 during cycles 3-5; done=1 in cycle 6 with sel_prim=0; busy low from cycle 7.
- Back-to-back: push (0,1), (18,2), (7,0) on consecutive cycles.
  - Expected sel_prim sequence: 0x00001, 0, 0x40000, 0x40000, 0, 0x00080, 0.
  - done pulses on each zero cycle that follows an issue.
- Full FIFO: hold cmd_valid with len=15 for 8 cycles -> exactly DEPTH+1 = 5 accepts (1 in issue + 4 buffered); cmd_ready=0 while full; re-asserts the cycle after the first pop.
- Invalid id: push id=19, then id=31 -> err_id pulses one cycle after each accept; sel_prim stays 0; done never asserts; FIFO stays empty.
- Abort mid-issue: id=3, len=10, with two more commands queued; assert abort at the 4th select cycle -> sel_prim=0 next cycle; no done; busy=0; FIFO empty; a cmd_valid held during abort is not accepted.
- Reset mid-issue: assert rst during the ISSUE of id=12 -> all outputs 0 after that edge; a subsequent push of id=1, len=1 issues normally with one-cycle latency.

Source files
------------

// File: rtl/prim_sel_sequencer_if.sv
// Command handshake between a primitive-command producer and prim_sel_sequencer.
interface prim_sel_sequencer_if #(
    parameter int ID_W  = 5,
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ID_W-1:0]  cmd_id;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_id, output cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_id, input cmd_len, output cmd_ready);
endinterface

// File: rtl/prim_sel_sequencer.sv
// Buffers {id,len} primitive commands and plays them out as a registered one-hot
// sel_prim, held len cycles, with one all-zero cycle between consecutive issues.
module prim_sel_sequencer #(
    parameter int NPRIM = 19,
    parameter int ID_W  = 5,
    parameter int LEN_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    prim_sel_sequencer_if.slave  cmd,
    input  logic                 abort,
    output logic [NPRIM-1:0]     sel_prim,
    output logic                 busy,
    output logic                 done,
    output logic                 err_id
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ID_W-1:0]  ID_LIMIT = ID_W'(NPRIM);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    function automatic logic [NPRIM-1:0] onehot(input logic [ID_W-1:0] id);
        return {{(NPRIM-1){1'b0}}, 1'b1} << id;
    endfunction

    function automatic logic [LEN_W-1:0] hold_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [ID_W-1:0]    r_mem_id  [DEPTH];
    logic [LEN_W-1:0]   r_mem_len [DEPTH];
    logic [LEN_W-1:0]   r_cnt;
    logic [NPRIM-1:0]   r_sel;
    logic               r_done;
    logic               r_err;

    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_finish;

    // Ready depends only on the registered count, so a pop cannot free a slot early.
    assign cmd.cmd_ready = (r_count != FULL_CNT) & ~abort;
    assign w_empty       = (r_count == '0);
    assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;
    assign w_push        = w_accept & (cmd.cmd_id < ID_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_finish    = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == LEN_W'(1)) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
                S_GAP: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            r_err   <= w_accept & ~w_push;
            if (abort) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_cnt   <= '0;
                r_sel   <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop)
                    r_rptr <= r_rptr + PTR_W'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + CNT_W'(1);
                else if (!w_push && w_pop)
                    r_count <= r_count - CNT_W'(1);

                if (w_pop) begin
                    r_sel <= onehot(r_mem_id[r_rptr]);
                    r_cnt <= hold_len(r_mem_len[r_rptr]);
                end else if (w_finish) begin
                    r_sel <= '0;
                end else if (r_state == S_ISSUE) begin
                    r_cnt <= r_cnt - LEN_W'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wptr]  <= cmd.cmd_id;
            r_mem_len[r_wptr] <= cmd.cmd_len;
        end
    end

    assign sel_prim = r_sel;
    assign done     = r_done;
    assign err_id   = r_err;
    assign busy     = !w_empty || (r_state != S_IDLE);
endmodule

// File: tb/tb_prim_sel_sequencer.sv
// Directed bench for prim_sel_sequencer with hand-computed expected sequences.
module tb_prim_sel_sequencer;
    logic        clk;
    logic        rst;
    logic        abort;
    logic [18:0] sel_prim;
    logic        busy;
    logic        done;
    logic        err_id;

    int n_chk;
    int n_err;

    prim_sel_sequencer_if #(.ID_W(5), .LEN_W(4)) u_if ();

    prim_sel_sequencer #(.NPRIM(19), .ID_W(5), .LEN_W(4), .DEPTH(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (u_if.slave),
        .abort    (abort),
        .sel_prim (sel_prim),
        .busy     (busy),
        .done     (done),
        .err_id   (err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] id, input logic [3:0] len);
        u_if.cmd_valid = v;
        u_if.cmd_id    = id;
        u_if.cmd_len   = len;
    endtask

    logic [18:0] exp_sel  [7];
    logic        exp_done [7];
    int          accepts;
    int          waited;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        abort = 1'b0;
        drive(1'b0, 5'd0, 4'd0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_sel",   32'(sel_prim), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        check("rst_err",   32'(err_id), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_ready", 32'(u_if.cmd_ready), 32'h1);

        // Basic issue: id=5 len=3
        drive(1'b1, 5'd5, 4'd3);
        step();
        drive(1'b0, 5'd0, 4'd0);
        check("basic_busy_q", 32'(busy), 32'h1);
        check("basic_sel_q",  32'(sel_prim), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("basic_sel", 32'(sel_prim), 32'h00020);
        end
        step();
        check("basic_gap_sel",  32'(sel_prim), 32'h0);
        check("basic_gap_done", 32'(done), 32'h1);
        check("basic_gap_busy", 32'(busy), 32'h1);
        step();
        check("basic_end_done", 32'(done), 32'h0);
        check("basic_end_busy", 32'(busy), 32'h0);

        // Back-to-back: (0,1), (18,2), (7,0)
        exp_sel[0] = 19'h00001; exp_done[0] = 1'b0;
        exp_sel[1] = 19'h00000; exp_done[1] = 1'b1;
        exp_sel[2] = 19'h40000; exp_done[2] = 1'b0;
        exp_sel[3] = 19'h40000; exp_done[3] = 1'b0;
        exp_sel[4] = 19'h00000; exp_done[4] = 1'b1;
        exp_sel[5] = 19'h00080; exp_done[5] = 1'b0;
        exp_sel[6] = 19'h00000; exp_done[6] = 1'b1;
        drive(1'b1, 5'd0, 4'd1);
        step();
        drive(1'b1, 5'd18, 4'd2);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) drive(1'b1, 5'd7, 4'd0);
            if (i == 1) drive(1'b0, 5'd0, 4'd0);
            check($sformatf("b2b_sel%0d", i),  32'(sel_prim), 32'(exp_sel[i]));
            check($sformatf("b2b_done%0d", i), 32'(done), 32'(exp_done[i]));
        end
        step();
        check("b2b_idle_busy", 32'(busy), 32'h0);

        // Full FIFO: valid held for 8 edges with len=15
        accepts = 0;
        drive(1'b1, 5'd2, 4'd15);
        for (int i = 0; i < 8; i++) begin
            if (u_if.cmd_ready) accepts++;
            step();
        end
        drive(1'b0, 5'd0, 4'd0);
        check("full_accepts", 32'(accepts), 32'd5);
        check("full_ready",   32'(u_if.cmd_ready), 32'h0);
        waited = 0;
        while (!u_if.cmd_ready && waited < 40) begin
            step();
            waited++;
        end
        check("full_ready_wait", 32'(waited), 32'd10);
        check("full_ready_sel",  32'(sel_prim), 32'h00004);
        abort = 1'b1;
        #1;
        check("abort_ready", 32'(u_if.cmd_ready), 32'h0);
        step();
        abort = 1'b0;
        check("full_flush_busy", 32'(busy), 32'h0);
        check("full_flush_sel",  32'(sel_prim), 32'h0);

        // Invalid ids 19 and 31
        drive(1'b1, 5'd19, 4'd1);
        step();
        drive(1'b1, 5'd31, 4'd1);
        check("inv_err0",  32'(err_id), 32'h1);
        check("inv_busy0", 32'(busy), 32'h0);
        step();
        drive(1'b0, 5'd0, 4'd0);
        check("inv_err1", 32'(err_id), 32'h1);
        check("inv_sel1", 32'(sel_prim), 32'h0);
        step();
        check("inv_err2",  32'(err_id), 32'h0);
        check("inv_sel2",  32'(sel_prim), 32'h0);
        check("inv_done2", 32'(done), 32'h0);
        check("inv_busy2", 32'(busy), 32'h0);

        // Abort mid-issue with two commands queued
        drive(1'b1, 5'd3, 4'd10);
        step();
        drive(1'b1, 5'd4, 4'd2);
        step();
        drive(1'b1, 5'd5, 4'd2);
        step();
        drive(1'b0, 5'd0, 4'd0);
        step();
        step();
        check("abt_sel_before", 32'(sel_prim), 32'h00008);
        abort = 1'b1;
        drive(1'b1, 5'd6, 4'd1);
        #1;
        check("abt_ready", 32'(u_if.cmd_ready), 32'h0);
        step();
        abort = 1'b0;
        drive(1'b0, 5'd0, 4'd0);
        check("abt_sel",  32'(sel_prim), 32'h0);
        check("abt_done", 32'(done), 32'h0);
        check("abt_busy", 32'(busy), 32'h0);
        step();
        check("abt_sel_after",  32'(sel_prim), 32'h0);
        check("abt_busy_after", 32'(busy), 32'h0);
        check("abt_done_after", 32'(done), 32'h0);

        // Reset mid-issue of id=12
        drive(1'b1, 5'd12, 4'd5);
        step();
        drive(1'b0, 5'd0, 4'd0);
        step();
        check("rmi_sel_before", 32'(sel_prim), 32'h01000);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmi_sel",   32'(sel_prim), 32'h0);
        check("rmi_done",  32'(done), 32'h0);
        check("rmi_busy",  32'(busy), 32'h0);
        check("rmi_err",   32'(err_id), 32'h0);
        check("rmi_ready", 32'(u_if.cmd_ready), 32'h1);
        drive(1'b1, 5'd1, 4'd1);
        step();
        drive(1'b0, 5'd0, 4'd0);
        check("post_sel_q", 32'(sel_prim), 32'h0);
        step();
        check("post_sel",   32'(sel_prim), 32'h00002);
        step();
        check("post_gap_sel",  32'(sel_prim), 32'h0);
        check("post_gap_done", 32'(done), 32'h1);
        step();
        check("post_done_end", 32'(done), 32'h0);
        check("post_busy_end", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
